// File: rtl/div_meas_pkg.sv
// Shared types and defaults for the divided-clock ratio monitor.
package div_meas_pkg;

   localparam int CNT_W_DEF    = 8;
   localparam int LOCK_CNT_DEF = 4;
   localparam int RUN_W        = 4;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      MEAS,
      LOCKED
   } meas_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus delay flop; reports the synchronized level and its edges.
module sync_edge_det (
   input  logic clk_in,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1, s2, s3;

   // NOTE: flops use non-blocking assignments so every stage samples the pre-edge value of the one before it.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= async_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign level = s2;
   assign rise  = s2 & ~s3;
   assign fall  = ~s2 & s3;

endmodule

// File: rtl/div_ratio_detect.sv
// Measures the period of clk_div in clk_in cycles and reports ratio, lock, timeout.
// Optional 50% duty check is built when DIV_RATIO_DUTY_CHECK_EN is defined.
module div_ratio_detect
   import div_meas_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int LOCK_CNT = LOCK_CNT_DEF
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             clk_div,
   output logic [CNT_W-1:0] ratio,
   output logic             ratio_valid,
   output logic             is_even,
   output logic             locked,
   output logic             mismatch,
   output logic             timeout,
   output logic             duty_err
);

   meas_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [RUN_W-1:0] run, run_nxt, run_inc;
   logic             sync_level, rise, fall;
   logic             cnt_sat, same, capture;
   logic             locked_nxt, mismatch_nxt, timeout_nxt;

   sync_edge_det u_sync (
      .clk_in   (clk_in),
      .rst      (rst),
      .async_in (clk_div),
      .level    (sync_level),
      .rise     (rise),
      .fall     (fall)
   );

   assign cnt_sat = &cnt;
   assign same    = (cnt == ratio);
   assign run_inc = run + RUN_W'(1);

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst)          cnt <= '0;
      else if (rise)     cnt <= CNT_W'(1);
      else if (!cnt_sat) cnt <= cnt + CNT_W'(1);
   end

   // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
   always_comb begin
      state_nxt    = state;
      run_nxt      = run;
      capture      = 1'b0;
      locked_nxt   = locked;
      mismatch_nxt = 1'b0;
      timeout_nxt  = timeout;
      if (rise) begin
         timeout_nxt = 1'b0;
         case (state)
            IDLE:  state_nxt = ARMED;
            ARMED: begin
               capture   = 1'b1;
               run_nxt   = RUN_W'(1);
               state_nxt = MEAS;
            end
            MEAS: begin
               capture = 1'b1;
               if (!same) begin
                  run_nxt = RUN_W'(1);
               end else if (run_inc == RUN_W'(LOCK_CNT)) begin
                  run_nxt    = run_inc;
                  locked_nxt = 1'b1;
                  state_nxt  = LOCKED;
               end else begin
                  run_nxt = run_inc;
               end
            end
            LOCKED: begin
               capture = 1'b1;
               if (!same) begin
                  mismatch_nxt = 1'b1;
                  locked_nxt   = 1'b0;
                  run_nxt      = RUN_W'(1);
                  state_nxt    = MEAS;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end else if (cnt_sat) begin
         // A rise in the saturating cycle is handled above and wins.
         timeout_nxt = 1'b1;
         locked_nxt  = 1'b0;
         state_nxt   = IDLE;
      end
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         run         <= '0;
         ratio       <= '0;
         ratio_valid <= 1'b0;
         is_even     <= 1'b0;
         locked      <= 1'b0;
         mismatch    <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_nxt;
         run         <= run_nxt;
         ratio_valid <= capture;
         locked      <= locked_nxt;
         mismatch    <= mismatch_nxt;
         timeout     <= timeout_nxt;
         if (capture) begin
            ratio   <= cnt;
            is_even <= ~cnt[0];
         end
      end
   end

`ifdef DIV_RATIO_DUTY_CHECK_EN
   logic [CNT_W-1:0] high_cnt, high_q;
   logic             duty_bad;

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         high_cnt <= '0;
         high_q   <= '0;
         duty_err <= 1'b0;
      end else begin
         if (rise)                         high_cnt <= CNT_W'(1);
         else if (sync_level && !(&high_cnt)) high_cnt <= high_cnt + CNT_W'(1);
         if (fall) high_q <= high_cnt;
         duty_err <= capture & duty_bad;
      end
   end

   // One extra bit so high*2 cannot wrap for long high phases.
   assign duty_bad = ({high_q, 1'b0} != {1'b0, cnt});
`else
   logic unused_level;
   assign unused_level = sync_level ^ fall;
   assign duty_err     = 1'b0;
`endif

endmodule
